// File: rtl/dafx_pkg.sv
// Shared definitions for the DAFX audio path: I2S frame geometry,
// transmitter state encoding and small arithmetic helpers.
package dafx_pkg;

  localparam int unsigned I2S_SLOTS_C    = 64;
  localparam int unsigned I2S_CH_SLOTS_C = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cs_i2s_tx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cs_i2s_clk_gen.sv
// I2S bit/word clock generator: divider and slot counters. All outputs
// describe the upcoming output cycle so the caller can register them.
module cs_i2s_clk_gen
  import dafx_pkg::*;
#(
  parameter int unsigned SCLK_DIV_P = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_en,
  input  logic                                 i_clr,
  output logic                                 o_sclk,
  output logic                                 o_lrck,
  output logic [$clog2(I2S_CH_SLOTS_C)-1:0]    o_slot,
  output logic                                 o_slot_start,
  output logic                                 o_frame_start
);

  localparam int unsigned DIV_W  = $clog2(SCLK_DIV_P);
  localparam int unsigned SLOT_W = $clog2(I2S_SLOTS_C);

  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_div_wrap;

  // i_clr together with i_en restarts the frame at slot 0; without i_en
  // the counters park at zero so the serial outputs idle low.
  always_comb begin
    w_div_wrap    = (r_div == DIV_W'(SCLK_DIV_P - 1));
    w_div_nxt     = '0;
    w_slot_nxt    = '0;
    o_frame_start = 1'b0;
    if (i_en && i_clr) begin
      o_frame_start = 1'b1;
    end else if (i_en) begin
      w_div_nxt     = w_div_wrap ? '0 : r_div + 1'b1;
      w_slot_nxt    = w_div_wrap ? r_slot + 1'b1 : r_slot;
      o_frame_start = w_div_wrap && (r_slot == SLOT_W'(I2S_SLOTS_C - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_slot <= '0;
    end else begin
      r_div  <= w_div_nxt;
      r_slot <= w_slot_nxt;
    end
  end

  assign o_sclk       = (w_div_nxt >= DIV_W'(SCLK_DIV_P / 2));
  assign o_lrck       = (w_slot_nxt >= SLOT_W'(I2S_CH_SLOTS_C));
  assign o_slot       = w_slot_nxt[SLOT_W-2:0];
  assign o_slot_start = (w_div_nxt == '0);

endmodule

// File: rtl/cs_i2s_tx.sv
// I2S transmitter: one-frame holding buffer, shift stage, run FSM and
// saturating underflow counter, serialising stereo PCM MSB-first.
module cs_i2s_tx
  import dafx_pkg::*;
#(
  parameter int unsigned AUDIO_WIDTH_P = 24,
  parameter int unsigned SCLK_DIV_P    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cr_enable,
  input  logic                     cmd_clr_underflow,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [AUDIO_WIDTH_P-1:0] tx_left,
  input  logic [AUDIO_WIDTH_P-1:0] tx_right,
  output logic                     cs_tx_lrck,
  output logic                     cs_tx_sclk,
  output logic                     cs_tx_sdout,
  output logic [15:0]              sr_underflow_cnt
);

  localparam int unsigned CH_SLOT_W = $clog2(I2S_CH_SLOTS_C);

  cs_i2s_tx_state_t r_state;

  logic                     r_buf_full;
  logic [AUDIO_WIDTH_P-1:0] r_buf_l;
  logic [AUDIO_WIDTH_P-1:0] r_buf_r;
  logic [AUDIO_WIDTH_P-1:0] r_sh_l;
  logic [AUDIO_WIDTH_P-1:0] r_sh_r;
  logic [15:0]              r_uf_cnt;

  logic                     w_start;
  logic                     w_en;
  logic                     w_sclk;
  logic                     w_lrck;
  logic [CH_SLOT_W-1:0]     w_slot;
  logic                     w_slot_start;
  logic                     w_frame_start;
  logic                     w_uf_inc;
  logic [AUDIO_WIDTH_P-1:0] w_word;
  logic [AUDIO_WIDTH_P-1:0] w_shifted;
  logic                     w_bit;

  assign w_start  = (r_state == IDLE) && cr_enable;
  assign w_en     = cr_enable;
  assign w_uf_inc = w_frame_start && !r_buf_full;
  assign tx_ready = ~r_buf_full;
  assign sr_underflow_cnt = r_uf_cnt;

  cs_i2s_clk_gen #(
    .SCLK_DIV_P (SCLK_DIV_P)
  ) u_clk_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_en),
    .i_clr         (w_start),
    .o_sclk        (w_sclk),
    .o_lrck        (w_lrck),
    .o_slot        (w_slot),
    .o_slot_start  (w_slot_start),
    .o_frame_start (w_frame_start)
  );

  // Channel slot s carries sample bit (W - s); slot 0 and slots past W are 0.
  always_comb begin
    w_word    = w_lrck ? r_sh_r : r_sh_l;
    w_shifted = '0;
    w_bit     = 1'b0;
    if ((w_slot != '0) && (32'(w_slot) <= AUDIO_WIDTH_P)) begin
      w_shifted = w_word >> (AUDIO_WIDTH_P - 32'(w_slot));
      w_bit     = w_shifted[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      cs_tx_lrck  <= 1'b0;
      cs_tx_sclk  <= 1'b0;
      cs_tx_sdout <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (cr_enable)  r_state <= RUN;
        RUN:     if (!cr_enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      cs_tx_lrck <= w_lrck;
      cs_tx_sclk <= w_sclk;
      if (!w_en) begin
        cs_tx_sdout <= 1'b0;
      end else if (w_slot_start) begin
        cs_tx_sdout <= w_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else if (w_frame_start && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (tx_valid && !r_buf_full) begin
      r_buf_full <= 1'b1;
      r_buf_l    <= tx_left;
      r_buf_r    <= tx_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (!w_en) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (w_frame_start) begin
      r_sh_l <= r_buf_full ? r_buf_l : '0;
      r_sh_r <= r_buf_full ? r_buf_r : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uf_cnt <= '0;
    end else if (cmd_clr_underflow) begin
      r_uf_cnt <= w_uf_inc ? 16'd1 : 16'd0;
    end else if (w_uf_inc) begin
      r_uf_cnt <= sat_inc16(r_uf_cnt);
    end
  end

endmodule

// File: tb/tb_cs_i2s_tx.sv
// Directed bench for cs_i2s_tx (24-bit samples, SCLK_DIV_P = 4): reset,
// frame serialisation, underflow counting, back-pressure, disable and saturation.
module tb_cs_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cr_enable = 1'b0;
  logic        cmd_clr_underflow = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] tx_left = '0;
  logic [23:0] tx_right = '0;
  logic        cs_tx_lrck;
  logic        cs_tx_sclk;
  logic        cs_tx_sdout;
  logic [15:0] sr_underflow_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  cs_i2s_tx #(
    .AUDIO_WIDTH_P (24),
    .SCLK_DIV_P    (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cr_enable         (cr_enable),
    .cmd_clr_underflow (cmd_clr_underflow),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_left           (tx_left),
    .tx_right          (tx_right),
    .cs_tx_lrck        (cs_tx_lrck),
    .cs_tx_sclk        (cs_tx_sclk),
    .cs_tx_sdout       (cs_tx_sdout),
    .sr_underflow_cnt  (sr_underflow_cnt)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pins();
    return {cs_tx_lrck, cs_tx_sclk, cs_tx_sdout};
  endfunction

  // Expected {lrck, sclk, sdout} at output cycle c of a frame carrying (l, r).
  function automatic logic [2:0] exp_pins(input int unsigned c, input logic [23:0] l,
                                          input logic [23:0] r);
    int unsigned slot = c / 4;
    int unsigned ch   = slot % 32;
    logic [23:0] s    = (slot >= 32) ? r : l;
    logic [23:0] t;
    logic        b    = 1'b0;
    if (ch >= 1 && ch <= 24) begin
      t = s >> (24 - ch);
      b = t[0];
    end
    return {(slot >= 32), ((c % 4) >= 2), b};
  endfunction

  // Entered at c = 0; returns at c = 0 of the following frame.
  task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                             input logic [15:0] exp_uf, input bit bp);
    for (int unsigned c = 0; c < 256; c++) begin
      chk($sformatf("%s_pins_c%0d", tag, c), {29'd0, pins()}, {29'd0, exp_pins(c, l, r)});
      if (bp && c == 1) begin
        tx_valid = 1'b0;
        chk("bp_second_accepted", {31'd0, tx_ready}, 32'd0);
      end
      if (c == 255) chk({tag, "_uf"}, {16'd0, sr_underflow_cnt}, {16'd0, exp_uf});
      step(1);
    end
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_pins", {29'd0, pins()}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_uf", {16'd0, sr_underflow_cnt}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single frame, written while idle
    tx_left = 24'h800001; tx_right = 24'h7FFFFF; tx_valid = 1'b1;
    chk("idle_ready", {31'd0, tx_ready}, 32'd1);
    step(1);
    tx_valid = 1'b0;
    chk("idle_buf_full", {31'd0, tx_ready}, 32'd0);
    step(3);
    chk("idle_pins", {29'd0, pins()}, 32'd0);
    cr_enable = 1'b1;
    step(1);
    chk("ready_after_load", {31'd0, tx_ready}, 32'd1);
    check_frame("f1", 24'h800001, 24'h7FFFFF, 16'd0, 1'b0);

    // Underflow: three empty frames
    chk("uf_first_empty", {16'd0, sr_underflow_cnt}, 32'd1);
    check_frame("e2", 24'h0, 24'h0, 16'd1, 1'b0);
    check_frame("e3", 24'h0, 24'h0, 16'd2, 1'b0);
    chk("uf_three", {16'd0, sr_underflow_cnt}, 32'd3);
    cmd_clr_underflow = 1'b1;
    step(1);
    cmd_clr_underflow = 1'b0;
    chk("uf_cleared", {16'd0, sr_underflow_cnt}, 32'd0);
    step(254);
    cmd_clr_underflow = 1'b1;
    step(1);
    cmd_clr_underflow = 1'b0;
    chk("uf_clear_with_inc", {16'd0, sr_underflow_cnt}, 32'd1);

    // Disable mid-frame with a frame buffered, then re-enable
    tx_left = 24'h123456; tx_right = 24'hABCDEF; tx_valid = 1'b1;
    chk("run_ready", {31'd0, tx_ready}, 32'd1);
    step(1);
    tx_valid = 1'b0;
    chk("run_buf_full", {31'd0, tx_ready}, 32'd0);
    step(99);
    cr_enable = 1'b0;
    step(1);
    chk("dis_pins_101", {29'd0, pins()}, 32'd0);
    step(1);
    chk("dis_pins_102", {29'd0, pins()}, 32'd0);
    chk("dis_buf_kept", {31'd0, tx_ready}, 32'd0);
    chk("dis_uf", {16'd0, sr_underflow_cnt}, 32'd1);
    step(3);
    cr_enable = 1'b1;
    step(1);
    chk("reen_ready", {31'd0, tx_ready}, 32'd1);
    check_frame("f5", 24'h123456, 24'hABCDEF, 16'd1, 1'b0);
    chk("uf_after_reen", {16'd0, sr_underflow_cnt}, 32'd2);

    // Back-pressure: two frames offered back to back
    tx_left = 24'hF0F0F0; tx_right = 24'h0F0F0F; tx_valid = 1'b1;
    chk("bp_first_ready", {31'd0, tx_ready}, 32'd1);
    step(1);
    tx_left = 24'hC00003; tx_right = 24'h5A5A5A;
    chk("bp_stall_c1", {31'd0, tx_ready}, 32'd0);
    step(254);
    chk("bp_stall_c255", {31'd0, tx_ready}, 32'd0);
    step(1);
    chk("bp_ready_after_load", {31'd0, tx_ready}, 32'd1);
    check_frame("fa", 24'hF0F0F0, 24'h0F0F0F, 16'd2, 1'b1);
    check_frame("fb", 24'hC00003, 24'h5A5A5A, 16'd2, 1'b0);
    chk("uf_after_bp", {16'd0, sr_underflow_cnt}, 32'd3);

    // Saturation from a preloaded count
    cr_enable = 1'b0;
    step(2);
    force dut.r_uf_cnt = 16'hFFFE;
    step(1);
    release dut.r_uf_cnt;
    chk("sat_preload", {16'd0, sr_underflow_cnt}, 32'h0000FFFE);
    cr_enable = 1'b1;
    step(1);
    chk("sat_reach", {16'd0, sr_underflow_cnt}, 32'h0000FFFF);
    step(512);
    chk("sat_hold", {16'd0, sr_underflow_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-frame with a frame buffered
    tx_left = 24'h00FF00; tx_right = 24'hFF00FF; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    chk("pre_rst_buf_full", {31'd0, tx_ready}, 32'd0);
    step(129);
    chk("pre_rst_pins", {29'd0, pins()}, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pins", {29'd0, pins()}, 32'd0);
    chk("async_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("async_rst_uf", {16'd0, sr_underflow_cnt}, 32'd0);
    step(1);
    rst_n = 1'b1;
    cr_enable = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
